// File: rtl/pc_move_engine.sv
// Computer opponent for the tic-tac-toe core: snapshots the board, scans win lines, block lines,
// then a preference order, and strobes pc with the chosen cell. Optional block scan: PC_MOVE_BLOCK_EN.
module pc_move_engine #(
  parameter logic [1:0] PLAYER_CODE = 2'b01,
  parameter logic [1:0] PC_CODE     = 2'b10,
  parameter int         HOLD_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] board,
  output logic [3:0]  pc_pos,
  output logic        pc,
  output logic        busy,
  output logic        done,
  output logic        no_move
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SCAN_WIN   = 3'd1;
  localparam logic [2:0] SCAN_BLOCK = 3'd2;
  localparam logic [2:0] SCAN_PREF  = 3'd3;
  localparam logic [2:0] ISSUE      = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;

  logic [2:0]  state;
  logic [3:0]  idx;
  logic [3:0]  hold_cnt;
  logic [17:0] snap;

  function automatic logic [11:0] line_cells(input logic [2:0] k);
    case (k)
      3'd0:    line_cells = {4'd2, 4'd1, 4'd0};
      3'd1:    line_cells = {4'd5, 4'd4, 4'd3};
      3'd2:    line_cells = {4'd8, 4'd7, 4'd6};
      3'd3:    line_cells = {4'd6, 4'd3, 4'd0};
      3'd4:    line_cells = {4'd7, 4'd4, 4'd1};
      3'd5:    line_cells = {4'd8, 4'd5, 4'd2};
      3'd6:    line_cells = {4'd8, 4'd4, 4'd0};
      default: line_cells = {4'd6, 4'd4, 4'd2};
    endcase
  endfunction

  function automatic logic [3:0] pref_cell(input logic [3:0] j);
    case (j)
      4'd0:    pref_cell = 4'd4;
      4'd1:    pref_cell = 4'd0;
      4'd2:    pref_cell = 4'd2;
      4'd3:    pref_cell = 4'd6;
      4'd4:    pref_cell = 4'd8;
      4'd5:    pref_cell = 4'd1;
      4'd6:    pref_cell = 4'd3;
      4'd7:    pref_cell = 4'd5;
      default: pref_cell = 4'd7;
    endcase
  endfunction

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
    logic [17:0] sh;
    sh = b >> (2 * i);
    cell_at = sh[1:0];
  endfunction

  logic [1:0]  code;
  logic [11:0] lc;
  logic [1:0]  c0, c1, c2;
  logic        line_hit;
  logic [3:0]  line_tgt;
  logic [3:0]  pref_tgt;
  logic        pref_free;

  // One line (or one preference candidate) is evaluated per clock from the snapshot.
  always_comb begin
    code      = (state == SCAN_BLOCK) ? PLAYER_CODE : PC_CODE;
    lc        = line_cells(idx[2:0]);
    c0        = cell_at(snap, lc[3:0]);
    c1        = cell_at(snap, lc[7:4]);
    c2        = cell_at(snap, lc[11:8]);
    line_hit  = ((c0 == code) && (c1 == code) && (c2 == 2'b00)) ||
                ((c0 == code) && (c1 == 2'b00) && (c2 == code)) ||
                ((c0 == 2'b00) && (c1 == code) && (c2 == code));
    line_tgt  = (c0 == 2'b00) ? lc[3:0] : ((c1 == 2'b00) ? lc[7:4] : lc[11:8]);
    pref_tgt  = pref_cell(idx);
    pref_free = (cell_at(snap, pref_tgt) == 2'b00);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      hold_cnt <= '0;
      snap     <= '0;
      pc_pos   <= '0;
      pc       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      no_move  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          snap    <= board;
          idx     <= '0;
          no_move <= 1'b0;
          busy    <= 1'b1;
          state   <= SCAN_WIN;
        end
        SCAN_WIN, SCAN_BLOCK: begin
          if (line_hit) begin
            pc_pos   <= line_tgt;
            pc       <= 1'b1;
            hold_cnt <= 4'(HOLD_CYCLES - 1);
            state    <= ISSUE;
          end else if (idx == 4'd7) begin
            idx <= '0;
`ifdef PC_MOVE_BLOCK_EN
            state <= (state == SCAN_WIN) ? SCAN_BLOCK : SCAN_PREF;
`else
            state <= SCAN_PREF;
`endif
          end else begin
            idx <= idx + 4'd1;
          end
        end
        SCAN_PREF: begin
          if (pref_free) begin
            pc_pos   <= pref_tgt;
            pc       <= 1'b1;
            hold_cnt <= 4'(HOLD_CYCLES - 1);
            state    <= ISSUE;
          end else if (idx == 4'd8) begin
            no_move <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ISSUE: begin
          if (hold_cnt == 4'd0) begin
            pc    <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_move_engine.sv
// Scoreboard bench for pc_move_engine: two instances (HOLD_CYCLES 1 and 3) share stimulus;
// expected decisions come from a line/preference model evaluated on the start-time board.
module tb_pc_move_engine;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [17:0]       board = '0;
  logic [1:0][3:0]   pc_pos_v;
  logic [1:0]        pc_v, busy_v, done_v, nm_v;

  always #5 clock = ~clock;

  pc_move_engine #(.HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .board(board),
    .pc_pos(pc_pos_v[0]), .pc(pc_v[0]), .busy(busy_v[0]), .done(done_v[0]), .no_move(nm_v[0]));

  pc_move_engine #(.HOLD_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .start(start), .board(board),
    .pc_pos(pc_pos_v[1]), .pc(pc_v[1]), .busy(busy_v[1]), .done(done_v[1]), .no_move(nm_v[1]));

  typedef struct {
    int e0;   // edge at which start is accepted
    int dec;  // decision edge relative to e0
    int tgt;
    bit nm;
  } exp_t;

  exp_t sb[$];
  int   ecount = 0;
  int   nvec = 0;
  int   nerr = 0;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int prefs[9] = '{4,0,2,6,8,1,3,5,7};

  always @(posedge clock) ecount <= ecount + 1;

  function automatic int hold_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [17:0] b);
    exp_t r;
    logic [1:0] c[9];
    logic [1:0] code;
    int base, npass, n, ne, emp;
    bit found;
    for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
`ifdef PC_MOVE_BLOCK_EN
    npass = 2;
`else
    npass = 1;
`endif
    r = '{e0: 0, dec: 0, tgt: 0, nm: 1'b0};
    found = 1'b0;
    base = 0;
    for (int p = 0; p < npass; p++) begin
      code = (p == 0) ? 2'b10 : 2'b01;
      for (int k = 0; k < 8; k++) begin
        n = 0; ne = 0; emp = 0;
        for (int j = 0; j < 3; j++) begin
          if (c[lines[k][j]] == code) n++;
          else if (c[lines[k][j]] == 2'b00) begin ne++; emp = lines[k][j]; end
        end
        if (!found && n == 2 && ne == 1) begin
          found = 1'b1; r.dec = base + k + 1; r.tgt = emp;
        end
      end
      base += 8;
    end
    for (int j = 0; j < 9; j++)
      if (!found && c[prefs[j]] == 2'b00) begin
        found = 1'b1; r.dec = base + j + 1; r.tgt = prefs[j];
      end
    if (!found) begin
      r.dec = base + 9; r.nm = 1'b1;
    end
    return r;
  endfunction

  // Monitor: per-instance read pointer into the scoreboard, checks at negedge.
  int rd[2]       = '{0, 0};
  int pc_cnt[2]   = '{0, 0};
  int first_pc[2] = '{0, 0};
  bit was_done[2] = '{1'b0, 1'b0};
  bit last_nm[2]  = '{1'b0, 1'b0};

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        rd[d] = sb.size(); pc_cnt[d] = 0; was_done[d] = 1'b0; last_nm[d] = 1'b0;
      end else begin
        if (was_done[d]) begin
          chk("busy_after_done", busy_v[d], 0);
          chk("done_one_cycle", done_v[d], 0);
          was_done[d] = 1'b0;
        end
        if (!busy_v[d] && !done_v[d]) chk("no_move_held", nm_v[d], last_nm[d]);
        if (rd[d] >= sb.size()) begin
          chk("idle_pc", pc_v[d], 0);
          chk("idle_done", done_v[d], 0);
        end else begin
          exp_t e;
          e = sb[rd[d]];
          if (pc_v[d]) begin
            if (pc_cnt[d] == 0) first_pc[d] = ecount;
            pc_cnt[d]++;
            chk("pc_pos_during_pc", pc_pos_v[d], e.tgt);
          end
          if (done_v[d]) begin
            chk("done_edge", ecount, e.e0 + e.dec + (e.nm ? 0 : hold_of(d)));
            chk("no_move", nm_v[d], e.nm);
            chk("busy_at_done", busy_v[d], 1);
            chk("pc_cycles", pc_cnt[d], e.nm ? 0 : hold_of(d));
            if (!e.nm) begin
              chk("pc_first_edge", first_pc[d], e.e0 + e.dec);
              chk("pc_pos_at_done", pc_pos_v[d], e.tgt);
            end
            last_nm[d]  = e.nm;
            pc_cnt[d]   = 0;
            was_done[d] = 1'b1;
            rd[d]++;
          end
        end
      end
    end
  end

  // Issue a request, then scramble board and pulse start while both instances are busy.
  task automatic run_req(input logic [17:0] b);
    exp_t m;
    int d1, d3;
    @(negedge clock);
    board = b; start = 1'b1;
    m = model(b);
    m.e0 = ecount + 1;
    sb.push_back(m);
    d1 = m.e0 + m.dec + (m.nm ? 0 : 1);
    d3 = m.e0 + m.dec + (m.nm ? 0 : 3);
    do begin
      @(negedge clock);
      board = 18'($urandom);
      start = (ecount + 1 <= d1 + 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end while (ecount < d3 + 1);
  endtask

  function automatic logic [17:0] rand_board();
    logic [17:0] b;
    int r;
    for (int i = 0; i < 9; i++) begin
      r = $urandom_range(0, 7);
      b[2*i +: 2] = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
    end
    return b;
  endfunction

  task automatic chk_zero(input string name);
    for (int d = 0; d < 2; d++)
      chk(name, {pc_pos_v[d], pc_v[d], busy_v[d], done_v[d], nm_v[d]}, 0);
  endtask

  initial begin
    int e0;
    #12;
    chk_zero("reset_state");
    @(negedge clock);
    reset = 1'b1;

    run_req(18'b0);                                   // empty board -> centre
    run_req(18'b00_00_00_00_01_01_00_10_10);          // win line 0 -> cell 2
    run_req(18'b00_00_00_00_01_00_00_10_01);          // block line 6 -> cell 8
    run_req(18'b01_10_01_10_10_01_01_01_10);          // full board -> no move
    run_req(18'b11_11_11_11_11_11_11_11_11);          // all 11 -> occupied, no move

    // Reset mid-scan: outputs clear at once and the request is dropped.
    @(negedge clock);
    board = 18'b0; start = 1'b1;
    e0 = ecount + 1;
    sb.push_back(model(18'b0));
    sb[sb.size()-1].e0 = e0;
    do begin
      @(negedge clock);
      start = ($urandom_range(0, 1) == 0);
    end while (ecount < e0 + 4);
    @(posedge clock);
    #1 reset = 1'b0;
    #1 chk_zero("async_reset");
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    run_req(18'b0);

    for (int n = 0; n < 40; n++) run_req(rand_board());

    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) chk("all_requests_completed", rd[d], sb.size());
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
